// File: rtl/sseg_pkg.sv
// Shared types, constants and helpers for the 7-segment scan capture block.
//   NUM_DIGITS  : digits on the multiplexed bus
//   HEX_GLYPH   : active-high gfedcba codes for hex digits 0..F
//   an_class_e  : classification of a sampled active-low digit enable
//   digit_cap_t : payload written into one digit slot on capture
package sseg_pkg;

   localparam int unsigned NUM_DIGITS = 8;
   localparam int unsigned SEG_W      = 8;
   localparam int unsigned GLYPH_W    = 7;
   localparam int unsigned NIB_W      = 4;
   localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

   localparam logic [GLYPH_W-1:0] HEX_GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   typedef enum logic [1:0] {
      AN_BLANK,
      AN_ONEHOT,
      AN_MULTI
   } an_class_e;

   typedef struct packed {
      logic [SEG_W-1:0] seg;
      logic [NIB_W-1:0] nibble;
      logic             ok;
   } digit_cap_t;

   // Blank = no digit driven; one-hot = exactly one enable low; anything else is a bus fault.
   function automatic an_class_e classify_an(input logic [NUM_DIGITS-1:0] an);
      int unsigned zeros;
      zeros = 32'($countones(~an));
      if (zeros == 0)      return AN_BLANK;
      else if (zeros == 1) return AN_ONEHOT;
      else                 return AN_MULTI;
   endfunction

   // Position of the (single) low bit of an active-low one-hot enable.
   function automatic logic [IDX_W-1:0] onehot_low_index(input logic [NUM_DIGITS-1:0] an);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!an[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sseg_glyph_decode.sv
// Combinational glyph decoder: maps a 7-bit active-high gfedcba pattern to its hex value.
//   pattern_i : segment pattern, bit 6 = g ... bit 0 = a
//   nibble_o  : glyph index 0..F, 0 when no glyph matches (combinational)
//   ok_o      : high when pattern_i is one of the 16 hex glyphs (combinational)
module sseg_glyph_decode
   import sseg_pkg::*;
(
   input  logic [GLYPH_W-1:0] pattern_i,
   output logic [NIB_W-1:0]   nibble_o,
   output logic               ok_o
);

   // Glyph codes are distinct, so at most one compare can hit.
   always_comb begin
      nibble_o = '0;
      ok_o     = 1'b0;
      for (int g = 0; g < 16; g++) begin
         if (pattern_i == HEX_GLYPH[g]) begin
            nibble_o = NIB_W'(g);
            ok_o     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sseg_scan_capture.sv
// Capture side of the multiplexed 7-segment bus: de-glitches each digit slot,
// rebuilds the 8-digit frame and flags complete frames.
//   clk, reset_n : clock, synchronous active-low reset
//   an           : active-low digit enables (one-hot when driving)
//   sseg         : active-low segments, bit 7 = dp, bits 6:0 = gfedcba
//   seg_out      : captured active-high patterns, digit i at [8i+7:8i]
//   hex_out      : decoded nibble per digit, digit i at [4i+3:4i]
//   hex_ok       : per-digit glyph-match flag
//   frame_valid  : one-cycle pulse when all digits captured since last pulse
//   an_err       : one-cycle pulse on entry into a multi-hot enable value
module sseg_scan_capture
   import sseg_pkg::*;
#(
   parameter int unsigned SETTLE = 4
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NUM_DIGITS-1:0]       an,
   input  logic [SEG_W-1:0]            sseg,
   output logic [NUM_DIGITS*SEG_W-1:0] seg_out,
   output logic [NUM_DIGITS*NIB_W-1:0] hex_out,
   output logic [NUM_DIGITS-1:0]       hex_ok,
   output logic                        frame_valid,
   output logic                        an_err
);

   localparam int unsigned CNT_W = $clog2(SETTLE + 1);
   localparam int unsigned SEG_BUS_W = NUM_DIGITS * SEG_W;
   localparam int unsigned HEX_BUS_W = NUM_DIGITS * NIB_W;

   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [SEG_W-1:0]      sseg_q, sseg_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [SEG_BUS_W-1:0]  seg_q, seg_d;
   logic [HEX_BUS_W-1:0]  hex_q, hex_d;
   logic [NUM_DIGITS-1:0] ok_q, ok_d;
   logic [NUM_DIGITS-1:0] seen_q, seen_d;
   logic                  fv_q, fv_d;
   logic                  err_q, err_d;

   logic                  changed_c;
   logic                  capture_c;
   logic [IDX_W-1:0]      idx_c;
   logic [NUM_DIGITS-1:0] seen_set_c;
   digit_cap_t            cap_c;
   logic [NIB_W-1:0]      dec_nib_c;
   logic                  dec_ok_c;

   assign changed_c = ({an, sseg} != {an_q, sseg_q});
   // Fires on exactly one edge per stable period: the counter saturates past SETTLE-1.
   assign capture_c = !changed_c && (cnt_q == CNT_W'(SETTLE - 1));
   assign idx_c     = onehot_low_index(an_q);

   sseg_glyph_decode u_decode (
      .pattern_i (~sseg_q[GLYPH_W-1:0]),
      .nibble_o  (dec_nib_c),
      .ok_o      (dec_ok_c)
   );

   assign cap_c = '{seg: ~sseg_q, nibble: dec_nib_c, ok: dec_ok_c};

   // Next-state: sampling/settle counter, capture write and frame tracking.
   always_comb begin
      an_d       = an_q;
      sseg_d     = sseg_q;
      cnt_d      = cnt_q;
      seg_d      = seg_q;
      hex_d      = hex_q;
      ok_d       = ok_q;
      seen_d     = seen_q;
      fv_d       = 1'b0;
      err_d      = 1'b0;
      seen_set_c = seen_q;

      if (changed_c) begin
         an_d   = an;
         sseg_d = sseg;
         cnt_d  = '0;
         // A segment-only change under the same faulty enable is not a new entry.
         err_d  = (an != an_q) && (classify_an(an) == AN_MULTI);
      end else begin
         if (cnt_q != CNT_W'(SETTLE)) cnt_d = cnt_q + CNT_W'(1);
         if (capture_c && (classify_an(an_q) == AN_ONEHOT)) begin
            seg_d[{idx_c, 3'b000} +: SEG_W] = cap_c.seg;
            hex_d[{idx_c, 2'b00}  +: NIB_W] = cap_c.nibble;
            ok_d[idx_c]                     = cap_c.ok;
            seen_set_c                      = seen_q | (NUM_DIGITS'(1) << idx_c);
            if (&seen_set_c) begin
               fv_d   = 1'b1;
               seen_d = '0;
            end else begin
               seen_d = seen_set_c;
            end
         end
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         an_q   <= '1;
         sseg_q <= '1;
         cnt_q  <= '0;
         seg_q  <= '0;
         hex_q  <= '0;
         ok_q   <= '0;
         seen_q <= '0;
         fv_q   <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         an_q   <= an_d;
         sseg_q <= sseg_d;
         cnt_q  <= cnt_d;
         seg_q  <= seg_d;
         hex_q  <= hex_d;
         ok_q   <= ok_d;
         seen_q <= seen_d;
         fv_q   <= fv_d;
         err_q  <= err_d;
      end
   end

   assign seg_out     = seg_q;
   assign hex_out     = hex_q;
   assign hex_ok      = ok_q;
   assign frame_valid = fv_q;
   assign an_err      = err_q;

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Directed, table-driven bench for sseg_scan_capture (SETTLE = 4).
module tb_sseg_scan_capture;

   localparam int unsigned SETTLE = 4;
   localparam int HOLD = SETTLE + 1;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  an;
   logic [7:0]  sseg;
   logic [63:0] seg_out;
   logic [31:0] hex_out;
   logic [7:0]  hex_ok;
   logic        frame_valid;
   logic        an_err;

   sseg_scan_capture #(.SETTLE(SETTLE)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .an          (an),
      .sseg        (sseg),
      .seg_out     (seg_out),
      .hex_out     (hex_out),
      .hex_ok      (hex_ok),
      .frame_valid (frame_valid),
      .an_err      (an_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  an;
      logic [7:0]  sseg;
      int          hold;
      logic [63:0] seg;
      logic [31:0] hex;
      logic [7:0]  ok;
      int          fv;
      int          err;
   } vec_t;

   localparam logic [63:0] FULL_SEG = 64'h077D_6D66_4F5B_063F;
   localparam logic [31:0] FULL_HEX = 32'h7654_3210;

   vec_t        tbl [22];
   logic [7:0]  dig_an [8];
   logic [7:0]  dig_ss [8];
   int          n_vec  = 0;
   int          n_chk  = 0;
   int          n_fail = 0;
   int          fv_cnt, err_cnt, fv_tot;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Drive one an/sseg pair for n edges, counting pulses seen #1 after each edge.
   task automatic apply(input logic [7:0] a, input logic [7:0] s, input int n,
                        output int fv, output int er);
      an   = a;
      sseg = s;
      fv   = 0;
      er   = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
         fv += int'(frame_valid);
         er += int'(an_err);
      end
      n_vec++;
   endtask

   initial begin
      dig_an = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
      dig_ss = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

      tbl[0]  = '{8'hFE, 8'hC0, 6, 64'h3F,                 32'h0,        8'h01, 0, 0};
      tbl[1]  = '{8'hFD, 8'hF9, 4, 64'h3F,                 32'h0,        8'h01, 0, 0};
      tbl[2]  = '{8'hFD, 8'hA4, 5, 64'h5B3F,               32'h20,       8'h03, 0, 0};
      tbl[3]  = '{8'hFE, 8'hC0, 5, 64'h5B3F,               32'h20,       8'h03, 0, 0};
      tbl[4]  = '{8'hFD, 8'hF9, 5, 64'h063F,               32'h10,       8'h03, 0, 0};
      tbl[5]  = '{8'hFB, 8'hA4, 5, 64'h5B_063F,            32'h210,      8'h07, 0, 0};
      tbl[6]  = '{8'hF7, 8'hB0, 5, 64'h4F5B_063F,          32'h3210,     8'h0F, 0, 0};
      tbl[7]  = '{8'hEF, 8'h99, 5, 64'h66_4F5B_063F,       32'h43210,    8'h1F, 0, 0};
      tbl[8]  = '{8'hDF, 8'h92, 5, 64'h6D66_4F5B_063F,     32'h543210,   8'h3F, 0, 0};
      tbl[9]  = '{8'hBF, 8'h82, 5, 64'h7D_6D66_4F5B_063F,  32'h6543210,  8'h7F, 0, 0};
      tbl[10] = '{8'h7F, 8'hF8, 5, FULL_SEG,               FULL_HEX,     8'hFF, 1, 0};
      for (int k = 0; k < 8; k++)
         tbl[11+k] = '{dig_an[k], dig_ss[k], HOLD, FULL_SEG, FULL_HEX, 8'hFF, (k == 7) ? 1 : 0, 0};
      tbl[19] = '{8'hFC, 8'hC0, 6, FULL_SEG,               FULL_HEX,     8'hFF, 0, 1};
      tbl[20] = '{8'hFF, 8'hC0, 6, FULL_SEG,               FULL_HEX,     8'hFF, 0, 0};
      tbl[21] = '{8'hFB, 8'hFF, 6, 64'h077D_6D66_4F00_063F, 32'h7654_3010, 8'hFB, 0, 0};

      // Reset with inputs toggling.
      reset_n = 1'b0;
      an      = 8'hFE;
      sseg    = 8'hC0;
      @(posedge clk); #1;
      an      = 8'h00;
      sseg    = 8'h12;
      @(posedge clk); #1;
      chk("reset seg_out", 64'(seg_out), 64'h0);
      chk("reset hex_out", 64'(hex_out), 64'h0);
      chk("reset hex_ok",  64'(hex_ok),  64'h0);
      chk("reset pulses",  64'({frame_valid, an_err}), 64'h0);
      an      = 8'hFF;
      sseg    = 8'hFF;
      reset_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 22; i++) begin
         apply(tbl[i].an, tbl[i].sseg, tbl[i].hold, fv_cnt, err_cnt);
         chk($sformatf("v%0d seg_out", i),     64'(seg_out), tbl[i].seg);
         chk($sformatf("v%0d hex_out", i),     64'(hex_out), 64'(tbl[i].hex));
         chk($sformatf("v%0d hex_ok", i),      64'(hex_ok),  64'(tbl[i].ok));
         chk($sformatf("v%0d frame_valid count", i), 64'(fv_cnt),  64'(tbl[i].fv));
         chk($sformatf("v%0d an_err count", i),      64'(err_cnt), 64'(tbl[i].err));
      end

      // Reset mid-frame discards seen digits.
      fv_tot = 0;
      for (int k = 0; k < 6; k++) begin
         apply(dig_an[k], dig_ss[k], HOLD, fv_cnt, err_cnt);
         fv_tot += fv_cnt;
      end
      chk("pre-reset frame_valid count", 64'(fv_tot), 64'd0);
      reset_n = 1'b0;
      @(posedge clk); #1;
      chk("mid reset seg_out", 64'(seg_out), 64'h0);
      chk("mid reset hex_ok",  64'(hex_ok),  64'h0);
      reset_n = 1'b1;
      fv_tot  = 0;
      for (int k = 6; k < 8; k++) begin
         apply(dig_an[k], dig_ss[k], HOLD, fv_cnt, err_cnt);
         fv_tot += fv_cnt;
      end
      chk("post-reset digits 6,7 frame_valid", 64'(fv_tot), 64'd0);
      chk("post-reset digits 6,7 hex_ok", 64'(hex_ok), 64'hC0);
      fv_tot = 0;
      for (int k = 0; k < 6; k++) begin
         apply(dig_an[k], dig_ss[k], HOLD, fv_cnt, err_cnt);
         fv_tot += fv_cnt;
      end
      chk("completed frame_valid count", 64'(fv_tot), 64'd1);
      chk("completed seg_out", 64'(seg_out), FULL_SEG);
      chk("completed hex_out", 64'(hex_out), 64'(FULL_HEX));

      // Capture edge boundary: nothing after SETTLE edges, update on edge SETTLE.
      apply(8'hFE, 8'hF9, SETTLE, fv_cnt, err_cnt);
      chk("edge SETTLE-1 seg0", 64'(seg_out[7:0]), 64'h3F);
      apply(8'hFE, 8'hF9, 1, fv_cnt, err_cnt);
      chk("edge SETTLE seg0", 64'(seg_out[7:0]), 64'h06);
      chk("edge SETTLE hex0", 64'(hex_out[3:0]), 64'h1);

      // dp passes through and is ignored by decode.
      apply(8'hFE, 8'h40, HOLD, fv_cnt, err_cnt);
      chk("dp seg0", 64'(seg_out[7:0]), 64'hBF);
      chk("dp hex0/ok0", 64'({hex_out[3:0], hex_ok[0]}), 64'h01);

      // Non-glyph pattern decodes to nibble 0, ok 0.
      apply(8'hFE, 8'hFE, HOLD, fv_cnt, err_cnt);
      chk("bad glyph seg0", 64'(seg_out[7:0]), 64'h01);
      chk("bad glyph hex0/ok0", 64'({hex_out[3:0], hex_ok[0]}), 64'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
